// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// State encoding, id-width rule and round-robin winner search.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MAX_NREQ = 8;

  function automatic int idw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Returns {found, index}; search starts just after the last grant.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input logic [2:0]          last,
    input int                  n
  );
    logic [3:0] r;
    int idx;
    r = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      if (k <= n && !r[3]) begin
        idx = (int'(last) + k) % n;
        if (valid[3'(idx)]) r = {1'b1, 3'(idx)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_share_arb_mul_core.sv
// Combinational unsigned WxW multiplier built from shifted
// partial products; the single datapath shared by all requesters.
module mul_core #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  logic [2*W-1:0] a_ext;

  assign a_ext = {{W{1'b0}}, a};

  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p + (a_ext << i);
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin front end for one shared multiplier: accept one
// request, compute for one cycle, hold the tagged result.
module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*W-1:0]      rsp_p,
  output logic [idw_of(NREQ)-1:0] rsp_id,
  output logic                busy
);

  localparam int IDW = idw_of(NREQ);

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] id;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [2*W-1:0] prod;

  logic [MAX_NREQ-1:0] valid_x;
  logic [3:0]          pick;
  logic                found;
  logic [IDW-1:0]      g;
  logic [NREQ-1:0]     gnt;

  assign valid_x = MAX_NREQ'(req_valid);
  assign pick    = rr_pick(valid_x, 3'(last_grant), NREQ);
  assign found   = pick[3];
  assign g       = pick[IDW-1:0];

  always_comb begin
    gnt = '0;
    if (found) gnt[g] = 1'b1;
  end

  // Ready depends only on state and valid, never on rsp_ready.
  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;

  mul_core #(.W(W)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      id         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_p      <= '0;
      rsp_id     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a       <= req_a[int'(g)*W +: W];
            op_b       <= req_b[int'(g)*W +: W];
            id         <= g;
            last_grant <= g;
            busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          rsp_p     <= prod;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb (NREQ=4, W=4).
// Each task drives one scenario and checks against hand values.
module tb_mul_share_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_p;
  logic [1:0]  rsp_id;
  logic        busy;

  int total = 0;
  int bad = 0;

  mul_share_arb #(.NREQ(4), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_a = 16'hFFFF;
    req_b = 16'hFFFF;
    rsp_ready = 1'b1;
    #3;
    total++;
    if (req_ready !== 4'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0000", req_ready);
    end
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b%b want=00", rsp_valid, busy);
    end
    total++;
    if (rsp_p !== 8'd0 || rsp_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_data got=%0d/%0d want=0/0", rsp_p, rsp_id);
    end
  endtask

  task automatic test_basic;
    apply_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    req_a[3:0] = 4'd3;
    req_b[3:0] = 4'd5;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_grant got=%b/%b want=0001/0", req_ready, busy);
    end
    @(posedge clk);
    #1 req_valid = 4'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_calc got=%b/%b/%b want=0000/1/0",
               req_ready, busy, rsp_valid);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_p !== 8'd15 || rsp_id !== 2'd0) begin
      bad++;
      $display("FAIL basic_rsp got=%b/%0d/%0d want=1/15/0",
               rsp_valid, rsp_p, rsp_id);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_resp got=%b want=1", busy);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done got=%b/%b want=0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_extremes;
    logic [3:0] va [2] = '{4'd15, 4'd0};
    logic [3:0] vb [2] = '{4'd15, 4'd9};
    logic [7:0] vp [2] = '{8'hE1, 8'h00};
    bit ok;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      req_valid = 4'b0001;
      req_a[3:0] = va[n];
      req_b[3:0] = vb[n];
      rsp_ready = 1'b1;
      wait_ready(ok);
      total++;
      if (!ok || req_ready !== 4'b0001) begin
        bad++;
        $display("FAIL ext_grant%0d got=%b want=0001", n, req_ready);
      end
      @(posedge clk);
      #1 req_valid = 4'b0;
      wait_rsp(ok);
      total++;
      if (!ok || rsp_p !== vp[n]) begin
        bad++;
        $display("FAIL ext_prod%0d got=%0d want=%0d", n, rsp_p, vp[n]);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_round_robin;
    int cnt [4] = '{0, 0, 0, 0};
    int exp;
    bit ok;
    apply_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    req_a = {4'd4, 4'd3, 4'd2, 4'd1};
    req_b = {4'd2, 4'd2, 4'd2, 4'd2};
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp = n % 4;
      wait_ready(ok);
      total++;
      if (!ok || req_ready !== 4'(1 << exp)) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b want=%b", n, req_ready,
                 4'(1 << exp));
      end
      if (n < 4) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
      end
      wait_rsp(ok);
      total++;
      if (!ok || rsp_id !== 2'(exp) || rsp_p !== 8'((exp + 1) * 2)) begin
        bad++;
        $display("FAIL rr_rsp%0d got=%0d/%0d want=%0d/%0d", n,
                 rsp_id, rsp_p, exp, (exp + 1) * 2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt[i] !== 1) begin
        bad++;
        $display("FAIL rr_fair%0d got=%0d want=1", i, cnt[i]);
      end
    end
    @(posedge clk);
    #1 req_valid = 4'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    apply_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b0011;
    req_a = {8'h00, 4'd2, 4'd7};
    req_b = {8'h00, 4'd3, 4'd9};
    rsp_ready = 1'b0;
    wait_ready(ok);
    total++;
    if (!ok || req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL bp_grant got=%b want=0001", req_ready);
    end
    wait_rsp(ok);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (!ok || rsp_valid !== 1'b1 || rsp_p !== 8'd63 ||
          rsp_id !== 2'd0 || req_ready !== 4'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%0d/%0d/%b want=1/63/0/0000",
                 k, rsp_valid, rsp_p, rsp_id, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL bp_release got=%b/%b want=0/0010",
               rsp_valid, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_rsp(ok);
    total++;
    if (!ok || rsp_p !== 8'd6 || rsp_id !== 2'd1) begin
      bad++;
      $display("FAIL bp_next got=%0d/%0d want=6/1", rsp_p, rsp_id);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_midop;
    bit ok;
    bit seen;
    apply_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    req_a = 16'h4321;
    req_b = 16'h2222;
    rsp_ready = 1'b1;
    wait_ready(ok);
    total++;
    if (!ok || req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_first got=%b want=0001", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_calc_busy got=%b want=1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
      bad++;
      $display("FAIL mid_in_reset got=%b/%b/%b want=0/0/0000",
               rsp_valid, busy, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mid_no_rsp got=1 want=0");
    end
    total++;
    if (!ok || req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_regrant got=%b want=0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_rsp(ok);
    @(posedge clk);
  endtask

  task automatic test_late_request;
    bit ok;
    apply_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    req_a = {4'd0, 4'd4, 4'd5, 4'd1};
    req_b = {4'd0, 4'd4, 4'd5, 4'd1};
    rsp_ready = 1'b1;
    wait_ready(ok);
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_rsp(ok);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_ready(ok);
    total++;
    if (!ok || req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL late_g1 got=%b want=0010", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0;
    @(posedge clk);
    #1 req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0 || rsp_id !== 2'd1 || rsp_p !== 8'd25) begin
        bad++;
        $display("FAIL late_hold%0d got=%b/%0d/%0d want=0000/1/25",
                 k, req_ready, rsp_id, rsp_p);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL late_g2 got=%b/%b want=0/0100", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0;
    wait_rsp(ok);
    total++;
    if (!ok || rsp_id !== 2'd2 || rsp_p !== 8'd16) begin
      bad++;
      $display("FAIL late_rsp2 got=%0d/%0d want=2/16", rsp_id, rsp_p);
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_late_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
